// File: rtl/conv_mc_engine.sv
// Multi-channel signed 2-D convolution engine: one MAC per cycle with on-the-fly zero padding,
// configurable stride and optional ReLU; each result is streamed and also collected into a flat vector.
module conv_mc_engine #(
    parameter int IN_CH    = 2,
    parameter int K_W      = 3,
    parameter int K_H      = 3,
    parameter int IMG_W    = 5,
    parameter int IMG_H    = 5,
    parameter int PAD      = 1,
    parameter int STRIDE   = 1,
    parameter int BITWIDTH = 8,
    parameter int ACC_W    = 22,
    localparam int RES_W    = (IMG_W - K_W + 2 * PAD) / STRIDE + 1,
    localparam int RES_H    = (IMG_H - K_H + 2 * PAD) / STRIDE + 1,
    localparam int IMG_BITS = IN_CH * IMG_H * IMG_W * BITWIDTH,
    localparam int WGT_BITS = IN_CH * K_H * K_W * BITWIDTH,
    localparam int RES_BITS = RES_H * RES_W * ACC_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                relu_en_i,
    input  logic [IMG_BITS-1:0] img_i,
    input  logic [WGT_BITS-1:0] weight_i,
    input  logic [BITWIDTH-1:0] bias_i,
    output logic                busy_o,
    output logic                res_valid_o,
    output logic [ACC_W-1:0]    res_data_o,
    output logic [7:0]          res_row_o,
    output logic [7:0]          res_col_o,
    output logic [RES_BITS-1:0] result_o,
    output logic                done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_WRITE,
        S_FIN
    } state_e;

    state_e                      state_q;
    logic [IMG_BITS-1:0]         img_q;
    logic [WGT_BITS-1:0]         wgt_q;
    logic signed [BITWIDTH-1:0]  bias_q;
    logic                        relu_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic [7:0]                  kx_q, ky_q, ch_q, row_q, col_q;
    logic                        busy_q, res_valid_q, done_q;
    logic signed [ACC_W-1:0]     res_data_q;
    logic [7:0]                  res_row_q, res_col_q;
    logic [RES_BITS-1:0]         result_q;

    int                          iy_d, ix_d;
    logic signed [BITWIDTH-1:0]  pix_d, wgt_d;
    logic signed [2*BITWIDTH-1:0] prod_d;
    logic signed [ACC_W-1:0]     sum_d, val_d;
    logic                        last_tap_d, last_win_d;

    // Tap fetch (padding resolves to zero), MAC sum and the biased/ReLU'd window value.
    always_comb begin
        iy_d   = int'(row_q) * STRIDE + int'(ky_q) - PAD;
        ix_d   = int'(col_q) * STRIDE + int'(kx_q) - PAD;
        pix_d  = '0;
        if (iy_d >= 0 && iy_d < IMG_H && ix_d >= 0 && ix_d < IMG_W) begin
            pix_d = img_q[((int'(ch_q) * IMG_H + iy_d) * IMG_W + ix_d) * BITWIDTH +: BITWIDTH];
        end
        wgt_d  = wgt_q[((int'(ch_q) * K_H + int'(ky_q)) * K_W + int'(kx_q)) * BITWIDTH +: BITWIDTH];
        prod_d = pix_d * wgt_d;
        sum_d  = acc_q + ACC_W'(prod_d);
        val_d  = sum_d + ACC_W'(bias_q);
        if (relu_q && val_d[ACC_W-1]) begin
            val_d = '0;
        end
        last_tap_d = (kx_q == 8'(K_W - 1)) && (ky_q == 8'(K_H - 1)) && (ch_q == 8'(IN_CH - 1));
        last_win_d = (col_q == 8'(RES_W - 1)) && (row_q == 8'(RES_H - 1));
    end

    // Control FSM; strobes are raised on the edge that enters WRITE/FIN so they line up with those states.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            img_q       <= '0;
            wgt_q       <= '0;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            ch_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            res_data_q  <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            result_q    <= '0;
        end else begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    img_q    <= img_i;
                    wgt_q    <= weight_i;
                    bias_q   <= bias_i;
                    relu_q   <= relu_en_i;
                    acc_q    <= '0;
                    result_q <= '0;
                    kx_q     <= '0;
                    ky_q     <= '0;
                    ch_q     <= '0;
                    row_q    <= '0;
                    col_q    <= '0;
                    state_q  <= S_MAC;
                end
                S_MAC: begin
                    if (last_tap_d) begin
                        acc_q       <= '0;
                        kx_q        <= '0;
                        ky_q        <= '0;
                        ch_q        <= '0;
                        res_data_q  <= val_d;
                        res_row_q   <= row_q;
                        res_col_q   <= col_q;
                        res_valid_q <= 1'b1;
                        result_q[(int'(row_q) * RES_W + int'(col_q)) * ACC_W +: ACC_W] <= val_d;
                        state_q     <= S_WRITE;
                    end else begin
                        acc_q <= sum_d;
                        if (kx_q != 8'(K_W - 1)) begin
                            kx_q <= kx_q + 8'd1;
                        end else begin
                            kx_q <= '0;
                            if (ky_q != 8'(K_H - 1)) begin
                                ky_q <= ky_q + 8'd1;
                            end else begin
                                ky_q <= '0;
                                ch_q <= ch_q + 8'd1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (last_win_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        if (col_q != 8'(RES_W - 1)) begin
                            col_q <= col_q + 8'd1;
                        end else begin
                            col_q <= '0;
                            row_q <= row_q + 8'd1;
                        end
                        state_q <= S_MAC;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_row_o   = res_row_q;
    assign res_col_o   = res_col_q;
    assign result_o    = result_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_conv_mc_engine.sv
// Randomised and directed bench for conv_mc_engine against a plain-arithmetic convolution model.
module tb_conv_mc_engine;

    localparam int IN_CH = 2, K_W = 3, K_H = 3, IMG_W = 5, IMG_H = 5, PAD = 1, STRIDE = 1;
    localparam int BW = 8, ACC_W = 22;
    localparam int RES_W = (IMG_W - K_W + 2 * PAD) / STRIDE + 1;
    localparam int RES_H = (IMG_H - K_H + 2 * PAD) / STRIDE + 1;
    localparam int N     = IN_CH * K_H * K_W;
    localparam int NOUT  = RES_W * RES_H;

    logic clk = 1'b0;
    logic rst, start, relu_en;
    logic [IN_CH*IMG_H*IMG_W*BW-1:0] img;
    logic [IN_CH*K_H*K_W*BW-1:0]     wgt;
    logic [BW-1:0]                   bias;
    logic                            busy, res_valid, done;
    logic [ACC_W-1:0]                res_data;
    logic [7:0]                      res_row, res_col;
    logic [NOUT*ACC_W-1:0]           result;

    logic                            s_start;
    logic [127:0]                    s_img;
    logic [31:0]                     s_wgt;
    logic [BW-1:0]                   s_bias;
    logic                            s_busy, s_valid, s_done;
    logic [ACC_W-1:0]                s_data;
    logic [7:0]                      s_row, s_col;
    logic [4*ACC_W-1:0]              s_result;

    int total = 0;
    int bad   = 0;

    int pix [IN_CH][IMG_H][IMG_W];
    int wt  [IN_CH][K_H][K_W];
    int bv;
    bit relu;
    longint exp_v [NOUT];

    always #5 clk = ~clk;

    conv_mc_engine dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .relu_en_i(relu_en),
        .img_i(img), .weight_i(wgt), .bias_i(bias),
        .busy_o(busy), .res_valid_o(res_valid), .res_data_o(res_data),
        .res_row_o(res_row), .res_col_o(res_col), .result_o(result), .done_o(done)
    );

    conv_mc_engine #(
        .IN_CH(1), .K_W(2), .K_H(2), .IMG_W(4), .IMG_H(4), .PAD(0), .STRIDE(2)
    ) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .relu_en_i(1'b0),
        .img_i(s_img), .weight_i(s_wgt), .bias_i(s_bias),
        .busy_o(s_busy), .res_valid_o(s_valid), .res_data_o(s_data),
        .res_row_o(s_row), .res_col_o(s_col), .result_o(s_result), .done_o(s_done)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model();
        logic signed [ACC_W-1:0] w;
        for (int r = 0; r < RES_H; r++) begin
            for (int c = 0; c < RES_W; c++) begin
                longint acc = 0;
                for (int ch = 0; ch < IN_CH; ch++)
                    for (int ky = 0; ky < K_H; ky++)
                        for (int kx = 0; kx < K_W; kx++) begin
                            int y = r * STRIDE + ky - PAD;
                            int x = c * STRIDE + kx - PAD;
                            if (y >= 0 && y < IMG_H && x >= 0 && x < IMG_W)
                                acc += longint'(pix[ch][y][x]) * longint'(wt[ch][ky][kx]);
                        end
                acc += bv;
                w = ACC_W'(acc);
                acc = w;
                if (relu && acc < 0) acc = 0;
                exp_v[r * RES_W + c] = acc;
            end
        end
    endfunction

    task automatic fill_const(input int p, input int w, input int b, input bit rl);
        foreach (pix[c, y, x]) pix[c][y][x] = p;
        foreach (wt[c, y, x]) wt[c][y][x] = w;
        bv = b;
        relu = rl;
    endtask

    task automatic fill_rand();
        foreach (pix[c, y, x]) pix[c][y][x] = int'($signed(8'($urandom)));
        foreach (wt[c, y, x]) wt[c][y][x] = int'($signed(8'($urandom)));
        bv = int'($signed(8'($urandom)));
        relu = 1'($urandom);
    endtask

    task automatic pack();
        foreach (pix[c, y, x]) img[((c * IMG_H + y) * IMG_W + x) * BW +: BW] = BW'(pix[c][y][x]);
        foreach (wt[c, y, x]) wgt[((c * K_H + y) * K_W + x) * BW +: BW] = BW'(wt[c][y][x]);
        bias    = BW'(bv);
        relu_en = relu;
    endtask

    // t counts cycles after the start edge; outputs are sampled on the falling edge.
    task automatic run(input string nm, input bit disturb, input bit do_rst, input bit hold);
        int k = 0;
        bit got_done = 0;
        pack();
        model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int t = 1; t <= 620; t++) begin
            @(negedge clk);
            if (disturb && t == 3)
                for (int i = 0; i < IN_CH * IMG_H * IMG_W; i++) img[i*BW +: BW] = BW'($urandom);
            if (disturb && t == 40) start = 1'b1;
            if (disturb && t == 41) start = 1'b0;
            if (t == 1) chk({nm, "_busy"}, busy, 1);
            if (t == 2) chk({nm, "_clr"}, |result, 0);
            if (do_rst && t == 100) rst = 1'b1;
            if (do_rst && t == 101) begin
                rst = 1'b0;
                chk({nm, "_rst_busy"}, busy, 0);
                chk({nm, "_rst_res"}, |result, 0);
                chk({nm, "_rst_data"}, |res_data, 0);
            end
            if (res_valid) begin
                if (k < NOUT) begin
                    chk($sformatf("%s_vt%0d", nm, k), t, 2 + N + k * (N + 1));
                    chk($sformatf("%s_vd%0d", nm, k), $signed(res_data), exp_v[k]);
                    chk($sformatf("%s_vr%0d", nm, k), res_row, k / RES_W);
                    chk($sformatf("%s_vc%0d", nm, k), res_col, k % RES_W);
                end else begin
                    chk({nm, "_extra_valid"}, k, NOUT - 1);
                end
                k++;
            end
            if (done) begin
                got_done = 1;
                chk({nm, "_done_t"}, t, 2 + NOUT * (N + 1));
                chk({nm, "_cnt"}, k, NOUT);
                for (int i = 0; i < NOUT; i++)
                    chk($sformatf("%s_res%0d", nm, i), $signed(result[i*ACC_W +: ACC_W]), exp_v[i]);
                break;
            end
        end
        chk({nm, "_done_seen"}, got_done, !do_rst);
        if (hold && got_done) begin
            @(negedge clk);
            @(negedge clk);
            chk({nm, "_restart"}, busy, 1);
            start = 1'b0;
            got_done = 0;
            for (int t = 0; t < 600 && !got_done; t++) begin
                @(negedge clk);
                if (done) got_done = 1;
            end
            chk({nm, "_redone"}, got_done, 1);
            chk({nm, "_rres0"}, $signed(result[ACC_W-1:0]), exp_v[0]);
        end
    endtask

    task automatic run_small();
        int k = 0;
        bit gd = 0;
        for (int i = 0; i < 16; i++) s_img[i*8 +: 8] = 8'd1;
        for (int i = 0; i < 4; i++) s_wgt[i*8 +: 8] = 8'd1;
        s_bias = 8'd2;
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int t = 1; t <= 60 && !gd; t++) begin
            @(negedge clk);
            if (s_valid) begin
                if (k < 4) begin
                    chk($sformatf("sm_vt%0d", k), t, 6 + k * 5);
                    chk($sformatf("sm_vd%0d", k), $signed(s_data), 6);
                    chk($sformatf("sm_vr%0d", k), s_row, k / 2);
                    chk($sformatf("sm_vc%0d", k), s_col, k % 2);
                end
                k++;
            end
            if (s_done) begin
                gd = 1;
                chk("sm_done_t", t, 22);
                chk("sm_cnt", k, 4);
                for (int i = 0; i < 4; i++)
                    chk($sformatf("sm_res%0d", i), $signed(s_result[i*ACC_W +: ACC_W]), 6);
            end
        end
        chk("sm_done_seen", gd, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_start = 1'b0; relu_en = 1'b0;
        img = '0; wgt = '0; bias = '0; s_img = '0; s_wgt = '0; s_bias = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", |res_data, 0);
        chk("rst_rowcol", {res_row, res_col}, 0);
        chk("rst_result", |result, 0);
        chk("rst_sm_busy", s_busy, 0);
        rst = 1'b0;

        fill_const(1, 1, 0, 0);
        run("ones", 0, 0, 0);
        chk("ones_corner", $signed(result[0 +: ACC_W]), 8);
        chk("ones_edge", $signed(result[2*ACC_W +: ACC_W]), 12);
        chk("ones_inner", $signed(result[12*ACC_W +: ACC_W]), 18);

        fill_const(-1, 1, -3, 0);
        run("neg", 0, 0, 0);
        chk("neg_inner", $signed(result[12*ACC_W +: ACC_W]), -21);
        chk("neg_corner", $signed(result[0 +: ACC_W]), -11);
        fill_const(-1, 1, -3, 1);
        run("negrelu", 0, 0, 0);

        fill_const(-128, -128, 127, 0);
        run("big", 0, 0, 0);
        chk("big_inner", $signed(result[12*ACC_W +: ACC_W]), 295039);

        fill_rand();
        run("dist", 1, 0, 0);
        fill_rand();
        run("hold", 0, 0, 1);
        fill_rand();
        run("rst", 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            fill_rand();
            run($sformatf("rnd%0d", i), 0, 0, 0);
        end

        run_small();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
